// File: rtl/sr_cond_pkg.sv
// Shared definitions for the SR-latch input conditioner.
//   chan_state_t          : per-channel debounce state
//   DEFAULT_STABLE_CYCLES : default acceptance window (10 ms at 100 MHz)
package sr_cond_pkg;

  localparam int DEFAULT_STABLE_CYCLES = 1000000;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHK_HI    = 2'd1,
    STABLE_HI = 2'd2,
    CHK_LO    = 2'd3
  } chan_state_t;

endpackage

// File: rtl/sr_input_conditioner_debounce_channel.sv
// debounce_channel: two-flop synchronizer, debounce FSM with stability
// counter, registered debounced level and one-cycle rising-edge strobe.
//   clk   : system clock
//   reset : synchronous, active-high
//   raw   : asynchronous, possibly bouncing switch input
//   level : debounced level
//   pulse : one-cycle strobe when level goes 0->1
//
// state     | meaning
// ----------+------------------------------------------------
// STABLE_LO | level is 0, synchronized input agrees
// CHK_HI    | input reads 1, counting toward acceptance of 1
// STABLE_HI | level is 1, synchronized input agrees
// CHK_LO    | input reads 0, counting toward acceptance of 0
module debounce_channel
  import sr_cond_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic pulse
);

  // The edge that loads the counter counts as the first stable cycle, so
  // acceptance happens on the edge where the count would reach
  // STABLE_CYCLES; the stored count therefore tops out one below it.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1, sync2;
  chan_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             level_nxt, pulse_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      state <= STABLE_LO;
      cnt   <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      state <= state_nxt;
      cnt   <= cnt_nxt;
      level <= level_nxt;
      pulse <= pulse_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = level;
    pulse_nxt = 1'b0;
    case (state)
      STABLE_LO: begin
        if (sync2) begin
          state_nxt = CHK_HI;
          cnt_nxt   = CNT_ONE;
        end
      end
      CHK_HI: begin
        if (!sync2) begin
          state_nxt = STABLE_LO;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = STABLE_HI;
          cnt_nxt   = '0;
          level_nxt = 1'b1;
          pulse_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!sync2) begin
          state_nxt = CHK_LO;
          cnt_nxt   = CNT_ONE;
        end
      end
      CHK_LO: begin
        if (sync2) begin
          state_nxt = STABLE_HI;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = STABLE_LO;
          cnt_nxt   = '0;
          level_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = STABLE_LO;
        cnt_nxt   = '0;
        level_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/sr_input_conditioner.sv
// sr_input_conditioner: debounces the S and R switches and produces safe
// drive for a downstream SR latch (never S=R=1).
//   clk     : system clock
//   reset   : synchronous, active-high
//   sw_s    : raw set switch
//   sw_r    : raw reset switch
//   s_out   : debounced level of sw_s
//   r_out   : debounced level of sw_r
//   s_pulse : one-cycle strobe on s_out 0->1
//   r_pulse : one-cycle strobe on r_out 0->1
//   s_cmd   : latch S drive, s_out & ~r_out (registered)
//   r_cmd   : latch R drive, r_out & ~s_out (registered)
//   invalid : both debounced levels high (registered)
module sr_input_conditioner
  import sr_cond_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_s,
  input  logic sw_r,
  output logic s_out,
  output logic r_out,
  output logic s_pulse,
  output logic r_pulse,
  output logic s_cmd,
  output logic r_cmd,
  output logic invalid
);

  debounce_channel #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_chan_s (
    .clk  (clk),
    .reset(reset),
    .raw  (sw_s),
    .level(s_out),
    .pulse(s_pulse)
  );

  debounce_channel #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_chan_r (
    .clk  (clk),
    .reset(reset),
    .raw  (sw_r),
    .level(r_out),
    .pulse(r_pulse)
  );

  // Both channels are treated symmetrically: when both levels are high the
  // latch is left holding (S=R=0) rather than favouring either side.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_cmd   <= 1'b0;
      r_cmd   <= 1'b0;
      invalid <= 1'b0;
    end else begin
      s_cmd   <= s_out & ~r_out;
      r_cmd   <= r_out & ~s_out;
      invalid <= s_out & r_out;
    end
  end

endmodule

// File: tb/tb_sr_input_conditioner.sv
module tb_sr_input_conditioner;

  localparam int SC = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sw_s = 1'b0;
  logic sw_r = 1'b0;
  logic s_out, r_out, s_pulse, r_pulse, s_cmd, r_cmd, invalid;

  int total = 0;
  int bad = 0;

  // {s_out, r_out, s_pulse, r_pulse, s_cmd, r_cmd, invalid}
  logic [6:0] exp_q[$];

  // expected debounced levels after the most recent edge
  logic pes = 1'b0;
  logic per = 1'b0;

  sr_input_conditioner #(.STABLE_CYCLES(SC)) dut (
    .clk    (clk),
    .reset  (reset),
    .sw_s   (sw_s),
    .sw_r   (sw_r),
    .s_out  (s_out),
    .r_out  (r_out),
    .s_pulse(s_pulse),
    .r_pulse(r_pulse),
    .s_cmd  (s_cmd),
    .r_cmd  (r_cmd),
    .invalid(invalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] want);
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b (s_out r_out s_pulse r_pulse s_cmd r_cmd invalid)",
               tag, obs, want);
    end
  endtask

  // One clock: drive inputs, queue the expected outputs after the coming
  // edge, then sample 1 time unit past the edge and compare.
  task automatic step(input string tag, input logic s, input logic r, input logic rst,
                      input logic es, input logic er);
    logic [6:0] e;
    logic [6:0] got;
    sw_s  = s;
    sw_r  = r;
    reset = rst;
    if (rst) e = 7'b0;
    else e = {es, er, es & ~pes, er & ~per, pes & ~per, per & ~pes, pes & per};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = {s_out, r_out, s_pulse, r_pulse, s_cmd, r_cmd, invalid};
    if (exp_q.size() == 0) begin
      chk({tag, "_noexp"}, got, 7'bx);
    end else begin
      chk(tag, got, exp_q.pop_front());
    end
    pes = rst ? 1'b0 : es;
    per = rst ? 1'b0 : er;
  endtask

  // Hold inputs for n edges; expected s level becomes s at edge s_at and
  // expected r level becomes r at edge r_at (0 = no change expected).
  task automatic drive(input string tag, input logic s, input logic r, input int n,
                       input int s_at, input int r_at);
    logic es;
    logic er;
    es = pes;
    er = per;
    for (int i = 1; i <= n; i++) begin
      if (i == s_at) es = s;
      if (i == r_at) er = r;
      step($sformatf("%s[%0d]", tag, i), s, r, 1'b0, es, er);
    end
  endtask

  task automatic do_reset(input string tag, input int n, input logic s, input logic r);
    for (int i = 1; i <= n; i++) step($sformatf("%s[%0d]", tag, i), s, r, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    do_reset("rst", 3, 1'b0, 1'b0);
    drive("idle", 1'b0, 1'b0, 20, 0, 0);

    drive("s_rise", 1'b1, 1'b0, 10, SC + 2, 0);
    drive("s_fall", 1'b0, 1'b0, 10, SC + 2, 0);

    drive("s_bounce_hi", 1'b1, 1'b0, 3, 0, 0);
    drive("s_bounce_lo", 1'b0, 1'b0, 10, 0, 0);

    for (int len = 1; len < SC; len++) begin
      drive($sformatf("r_glitch%0d", len), 1'b0, 1'b1, len, 0, 0);
      drive($sformatf("r_glitch%0d_lo", len), 1'b0, 1'b0, 8, 0, 0);
    end

    drive("s_acc", 1'b1, 1'b0, 8, SC + 2, 0);
    drive("r_acc", 1'b1, 1'b1, 8, 0, SC + 2);
    drive("r_rel", 1'b1, 1'b0, 8, 0, SC + 2);
    drive("s_rel", 1'b0, 1'b0, 8, SC + 2, 0);

    drive("s_partial", 1'b1, 1'b0, 4, 0, 0);
    do_reset("mid_rst", 1, 1'b1, 1'b0);
    drive("s_after_rst", 1'b1, 1'b0, 10, SC + 2, 0);
    drive("s_after_rst_rel", 1'b0, 1'b0, 8, SC + 2, 0);

    drive("both_rise", 1'b1, 1'b1, 8, SC + 2, SC + 2);
    drive("both_fall", 1'b0, 1'b0, 8, SC + 2, SC + 2);

    do_reset("rst_held_hi", 2, 1'b0, 1'b1);
    drive("r_after_rst", 1'b0, 1'b1, 8, 0, SC + 2);
    drive("r_after_rst_rel", 1'b0, 1'b0, 8, 0, SC + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sr_input_conditioner.md
SR_INPUT_CONDITIONER -- requirements
Module: sr_input_conditioner

Interface
REQ-001 Parameter: STABLE_CYCLES, default 1000000, consecutive clk cycles an input must hold a new value before it is accepted (10 ms at 100 MHz); legal range >= 2.
REQ-002 Parameter: CNT_W, default $clog2(STABLE_CYCLES+1), stability counter width; derived, never overridden.
REQ-003 clk  input  1  system clock, 100 MHz board oscillator; all state on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 sw_s  input  1  raw asynchronous set switch (SW0), may bounce.
REQ-006 sw_r  input  1  raw asynchronous reset switch (SW1), may bounce.
REQ-007 s_out  output  1  debounced level of sw_s.
REQ-008 r_out  output  1  debounced level of sw_r.
REQ-009 s_pulse  output  1  one-cycle strobe on s_out 0->1.
REQ-010 r_pulse  output  1  one-cycle strobe on r_out 0->1.
REQ-011 s_cmd  output  1  safe S drive for downstream SR latch.
REQ-012 r_cmd  output  1  safe R drive for downstream SR latch.
REQ-013 invalid  output  1  high while both debounced levels are 1.

Function
REQ-014 Each raw input SHALL pass a two-flop synchronizer before any other logic; sync output = value of second flop.
REQ-015 Each channel SHALL run a 4-state FSM: STABLE_LO, CHK_HI, STABLE_HI, CHK_LO.
REQ-016 STABLE_LO -> CHK_HI when sync=1 (counter loads 1); STABLE_HI -> CHK_LO when sync=0 (counter loads 1).
REQ-017 In CHK_x: sync still differs -> counter+1; counter reaching STABLE_CYCLES -> enter STABLE_x, update level, clear counter; sync reverts -> return to previous STABLE state, clear counter, level unchanged.
REQ-018 Latency: a raw change held steady SHALL appear on s_out/r_out exactly STABLE_CYCLES+2 rising edges after the first synchronizer flop samples it.
REQ-019 Any glitch or bounce shorter than STABLE_CYCLES synchronized cycles SHALL cause no level change and no pulse.
REQ-020 s_pulse/r_pulse SHALL assert on the same edge the level goes 0->1 and deassert on the next edge; no pulse on 1->0.
REQ-021 invalid, s_cmd, r_cmd SHALL be registered, updated one edge after the debounced levels: invalid = s_out&r_out; s_cmd = s_out&~r_out; r_cmd = r_out&~s_out.
REQ-022 Both levels high: s_cmd=r_cmd=0 (latch holds), invalid=1; the 1,1 combination SHALL never reach the cmd outputs.
REQ-023 Simultaneous acceptance of both channels on one edge SHALL be handled per REQ-021 with no priority between channels.
REQ-024 Counter SHALL never exceed STABLE_CYCLES nor wrap.

Reset
REQ-025 reset high at a clk edge SHALL force: synchronizer flops 0, both FSMs STABLE_LO, counters 0, all outputs 0.
REQ-026 reset mid-check SHALL discard partial counts; after release, a full STABLE_CYCLES window is required again.
REQ-027 Switches already high at reset release SHALL be accepted per REQ-018, producing a pulse.

Structure
REQ-028 Shared package sr_cond_pkg SHALL hold the channel state enum (STABLE_LO, CHK_HI, STABLE_HI, CHK_LO) and the default STABLE_CYCLES constant.
REQ-029 One sub-module debounce_channel (synchronizer, FSM, counter, level, pulse) SHALL be instantiated twice; invalid/cmd logic stays in the top.

Verification (bench uses STABLE_CYCLES=4)
REQ-030 Reset 3 cycles, switches 0 -> all outputs 0, held 0 for 20 cycles.
REQ-031 sw_s 0->1 held -> s_out=1 at edge 6, s_pulse=1 for exactly edge 6, s_cmd=1 at edge 7, r_cmd=0.
REQ-032 sw_s high 3 cycles then low (bounce) -> s_out, s_pulse, s_cmd remain 0 throughout.
REQ-033 s accepted, then sw_r 0->1 held -> r_out=1 at edge 6, invalid=1 and s_cmd=r_cmd=0 at edge 7; sw_r released -> s_cmd=1, invalid=0 at edge 7 after release.
REQ-034 sw_s high, reset pulsed when counter=2 -> all outputs 0; after release s_out rises exactly 6 edges later, one s_pulse.
REQ-035 sw_s 1->0 after acceptance -> s_out=0 at edge 6, no s_pulse, s_cmd=0 at edge 7.
